// File: rtl/key_note_ctrl.sv
// Key-to-note front end for the audio codec: synchronises and debounces eight
// push buttons, picks the lowest pressed key and drives key-on gate and ramp step.
module key_note_ctrl #(
  parameter int TICK_DIV  = 18432,
  parameter int DEB_TICKS = 10,
  parameter int REL_TICKS = 50,
  parameter int GAP_CYC   = 768
) (
  input  logic        iCLK_18_4,
  input  logic        iRST_N,
  input  logic [7:0]  iKEY_N,
  input  logic [1:0]  iOct,
  output logic        oKey_on,
  output logic [15:0] oStep,
  output logic [2:0]  oNote,
  output logic        oNote_stb
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int RW = $clog2(REL_TICKS + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_TICKS);
  localparam logic [RW-1:0] REL_MAX   = RW'(REL_TICKS);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, GAP, PLAY, REL} state_t;

  logic [7:0]    sync1, kv, prev_kv, deb_keys;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [DW-1:0] stab_cnt, stab_inc;
  logic [2:0]    sel;
  logic          any;
  state_t        state, state_next;
  logic [2:0]    note, note_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic [RW-1:0] rel_cnt, rel_next;
  logic          play_entry;

  function automatic logic [15:0] note_step(input logic [2:0] n, input logic [1:0] oct);
    logic [15:0] base;
    case (n)
      3'd0:    base = 16'd335;
      3'd1:    base = 16'd376;
      3'd2:    base = 16'd422;
      3'd3:    base = 16'd447;
      3'd4:    base = 16'd502;
      3'd5:    base = 16'd563;
      3'd6:    base = 16'd632;
      default: base = 16'd670;
    endcase
    return base << oct;
  endfunction

  // Keys are active-low on the pins; inverted once here so 1 means pressed.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1 <= '0;
      kv    <= '0;
    end else begin
      sync1 <= ~iKEY_N;
      kv    <= sync1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign stab_inc = stab_cnt + 1'b1;

  // The whole vector is accepted only after DEB_TICKS consecutive equal samples.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      prev_kv  <= '0;
      stab_cnt <= '0;
      deb_keys <= '0;
    end else if (tick) begin
      prev_kv <= kv;
      if (kv != prev_kv) begin
        stab_cnt <= '0;
      end else if (stab_cnt == DEB_MAX) begin
        deb_keys <= kv;
      end else begin
        stab_cnt <= stab_inc;
        if (stab_inc == DEB_MAX) deb_keys <= kv;
      end
    end
  end

  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (deb_keys[i]) sel = 3'(i);
    end
    any = |deb_keys;
  end

  always_comb begin
    state_next = state;
    note_next  = note;
    gap_next   = gap_cnt;
    rel_next   = rel_cnt;
    play_entry = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          note_next  = sel;
          gap_next   = '0;
          state_next = GAP;
        end
      end
      GAP: begin
        // Key changes only re-latch the note; the gap length is never restarted.
        if (any) note_next = sel;
        if (gap_cnt == GAP_LAST) begin
          gap_next   = '0;
          state_next = PLAY;
          play_entry = 1'b1;
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end
      PLAY: begin
        if (!any) begin
          rel_next   = '0;
          state_next = REL;
        end else if (sel != note) begin
          note_next  = sel;
          gap_next   = '0;
          state_next = GAP;
        end
      end
      REL: begin
        if (any) begin
          note_next  = sel;
          gap_next   = '0;
          state_next = GAP;
        end else if (rel_cnt == REL_MAX) begin
          state_next = IDLE;
        end else if (tick) begin
          rel_next = rel_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      note      <= '0;
      gap_cnt   <= '0;
      rel_cnt   <= '0;
      oKey_on   <= 1'b0;
      oStep     <= '0;
      oNote     <= '0;
      oNote_stb <= 1'b0;
    end else begin
      state     <= state_next;
      note      <= note_next;
      gap_cnt   <= gap_next;
      rel_cnt   <= rel_next;
      oKey_on   <= (state_next == PLAY) || (state_next == REL);
      oNote_stb <= play_entry;
      if (play_entry) begin
        oStep <= note_step(note_next, iOct);
        oNote <= note_next;
      end
    end
  end

endmodule
